// File: rtl/pipelined_cond_sum_adder_if.sv
// Valid/ready operation and result channels of the pipelined conditional-sum adder.
// master drives operations and result acceptance; slave is the adder itself.
interface pipelined_cond_sum_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_y;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_y, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_y, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_cond_sum_adder.sv
// Pipelined conditional-sum adder/subtractor: leaf chunks compute sums for both carry-ins,
// then log2(N/CHUNK) registered levels merge neighbouring groups; final mux picks by carry-in.
module pipelined_cond_sum_adder #(
    parameter int N     = 32,
    parameter int CHUNK = 4
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_cond_sum_adder_if.slave bus
);
    localparam int NCHUNK = N / CHUNK;
    localparam int LEVELS = $clog2(NCHUNK);

    if (((N % CHUNK) != 0) || ((NCHUNK & (NCHUNK - 1)) != 0)) begin : g_bad_param
        $error("pipelined_cond_sum_adder: N must be CHUNK times a power of two");
    end

    logic [LEVELS:0] vld_r;
    logic [LEVELS:0] load_s;
    logic [N-1:0]    out_y_s;

    // A stage may load when it is empty or its successor takes its contents this cycle.
    always_comb begin
        load_s         = '0;
        load_s[LEVELS] = ~vld_r[LEVELS] | bus.out_ready;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            load_s[k] = ~vld_r[k] | load_s[k+1];
        end
    end

    // Per-stage valid bits shift forward only where a stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else begin
            if (load_s[0]) begin
                vld_r[0] <= bus.in_valid;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                if (load_s[k]) begin
                    vld_r[k] <= vld_r[k-1];
                end
            end
        end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : stg
        localparam int NG = NCHUNK >> k;

        logic [N-1:0]  s0_r, s1_r, nxt_s0, nxt_s1;
        logic [NG-1:0] c0_r, c1_r, nxt_c0, nxt_c1;
        logic          ceff_r, amsb_r, bmsb_r;
        logic          nxt_ceff, nxt_amsb, nxt_bmsb;

        if (k == 0) begin : g_leaf
            logic [N-1:0] b_eff_s;
            logic [CHUNK:0] sum0_s, sum1_s;

            // Leaf chunk adders evaluated for both possible chunk carry-ins.
            always_comb begin
                b_eff_s  = bus.in_sub ? ~bus.in_b : bus.in_b;
                nxt_ceff = bus.in_sub ? 1'b1 : bus.in_cin;
                nxt_amsb = bus.in_a[N-1];
                nxt_bmsb = b_eff_s[N-1];
                nxt_s0   = '0;
                nxt_s1   = '0;
                nxt_c0   = '0;
                nxt_c1   = '0;
                sum0_s   = '0;
                sum1_s   = '0;
                for (int c = 0; c < NCHUNK; c++) begin
                    sum0_s = {1'b0, bus.in_a[c*CHUNK +: CHUNK]} + {1'b0, b_eff_s[c*CHUNK +: CHUNK]};
                    sum1_s = sum0_s + {{CHUNK{1'b0}}, 1'b1};
                    nxt_s0[c*CHUNK +: CHUNK] = sum0_s[CHUNK-1:0];
                    nxt_s1[c*CHUNK +: CHUNK] = sum1_s[CHUNK-1:0];
                    nxt_c0[c] = sum0_s[CHUNK];
                    nxt_c1[c] = sum1_s[CHUNK];
                end
            end
        end else begin : g_merge
            localparam int HW = CHUNK << (k - 1);
            localparam int W  = CHUNK << k;

            // Upper half of each merged group follows the lower half's carry for each hypothesis.
            always_comb begin
                nxt_s0   = stg[k-1].s0_r;
                nxt_s1   = stg[k-1].s1_r;
                nxt_c0   = '0;
                nxt_c1   = '0;
                nxt_ceff = stg[k-1].ceff_r;
                nxt_amsb = stg[k-1].amsb_r;
                nxt_bmsb = stg[k-1].bmsb_r;
                for (int i = 0; i < N; i++) begin
                    if ((i % W) >= HW) begin
                        nxt_s0[i] = stg[k-1].c0_r[2*(i/W)] ? stg[k-1].s1_r[i] : stg[k-1].s0_r[i];
                        nxt_s1[i] = stg[k-1].c1_r[2*(i/W)] ? stg[k-1].s1_r[i] : stg[k-1].s0_r[i];
                    end else begin
                        nxt_s0[i] = stg[k-1].s0_r[i];
                        nxt_s1[i] = stg[k-1].s1_r[i];
                    end
                end
                for (int g = 0; g < NG; g++) begin
                    nxt_c0[g] = stg[k-1].c0_r[2*g] ? stg[k-1].c1_r[2*g+1] : stg[k-1].c0_r[2*g+1];
                    nxt_c1[g] = stg[k-1].c1_r[2*g] ? stg[k-1].c1_r[2*g+1] : stg[k-1].c0_r[2*g+1];
                end
            end
        end

        // Stage data register; holds while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_r   <= '0;
                s1_r   <= '0;
                c0_r   <= '0;
                c1_r   <= '0;
                ceff_r <= 1'b0;
                amsb_r <= 1'b0;
                bmsb_r <= 1'b0;
            end else if (load_s[k]) begin
                s0_r   <= nxt_s0;
                s1_r   <= nxt_s1;
                c0_r   <= nxt_c0;
                c1_r   <= nxt_c1;
                ceff_r <= nxt_ceff;
                amsb_r <= nxt_amsb;
                bmsb_r <= nxt_bmsb;
            end
        end
    end

    assign out_y_s       = stg[LEVELS].ceff_r ? stg[LEVELS].s1_r : stg[LEVELS].s0_r;
    assign bus.in_ready  = load_s[0];
    assign bus.out_valid = vld_r[LEVELS];
    assign bus.out_y     = out_y_s;
    assign bus.out_cout  = stg[LEVELS].ceff_r ? stg[LEVELS].c1_r[0] : stg[LEVELS].c0_r[0];
    assign bus.out_ovf   = (stg[LEVELS].amsb_r == stg[LEVELS].bmsb_r) &&
                           (out_y_s[N-1] != stg[LEVELS].amsb_r);
endmodule

// File: doc/pipelined_cond_sum_adder.md
Name: pipelined_cond_sum_adder

Overview:
- Pipelined, parametrised conditional-sum adder/subtractor with a valid/ready handshake at both ends.
- The operand is split into NCHUNK = N/CHUNK chunks. Each chunk forms a sum for carry-in 0 and a sum for carry-in 1.
- Pairs of chunks are merged in log2(NCHUNK) registered levels.
- Sits in the datapath where wide add/sub must close timing at high clock rate; full throughput of one operation per cycle under backpressure.

Parameters:
- N, 32, operand/result width.
- CHUNK, 4, width of the leaf chunk adder. N mod CHUNK must be 0 and N/CHUNK must be a power of 2, otherwise elaboration error.
- LEVELS, $clog2(N/CHUNK), derived merge-level count; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  1 selects A-B, 0 selects A+B+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  N  result.
- out_cout  out  1  carry out of bit N-1; for subtract, 1 means no borrow.
- out_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Effective operands: b_eff = in_sub ? ~in_b : in_b; c_eff = in_sub ? 1 : in_cin.
- Stage 0 (leaf), per chunk k:
  - register (s0_k, c0_k) = a_k + b_eff_k + 0.
  - register (s1_k, c1_k) = a_k + b_eff_k + 1.
  - register sideband c_eff, a[N-1], b_eff[N-1].
- Merge level l = 1..LEVELS, one register stage each; combines adjacent groups lo/hi, each of width CHUNK*2^(l-1):
  - For h in {0,1}: s_h = {c_lo_h ? s1_hi : s0_hi, s_lo_h}.
  - For h in {0,1}: c_h = c_lo_h ? c1_hi : c0_hi.
  - Sideband is forwarded unchanged.
- Output, from the last stage registers through a mux only:
  - out_y = c_eff ? s1 : s0; out_cout = c_eff ? c1 : c0.
  - out_ovf = (a_msb == beff_msb) && (out_y[N-1] != a_msb).
- Latency: LEVELS+1 cycles from input handshake (in_valid & in_ready) to out_valid. With N=32, CHUNK=4 this is 4 cycles; NCHUNK=1 gives 1 cycle.
- Pipeline control:
  - One valid bit per stage, stages 0..LEVELS.
  - Stage k loads when it is empty or stage k+1 advances this cycle. The last stage advances on out_ready.
  - in_ready = stage 0 empty or stage 0 advancing. This is combinational from out_ready through the stage chain; there is no skid buffer.
  - A stalled stage holds its data and valid bit unchanged.
- Handshake rules:
  - out_valid/out_y/out_cout/out_ovf remain stable while out_valid=1 and out_ready=0.
  - in_* is sampled only on an input handshake.
  - Order is preserved; no drop, no duplication.
- Capacity: LEVELS+1 in-flight operations. When every stage is full and out_ready=0, in_ready=0.
- Simultaneous accept and emit with a full pipeline and out_ready=1 sustains one operation per cycle.
- Reset:
  - rst_n low, at any time including mid-operation, asynchronously clears all valid bits.
  - Data registers clear to 0, so out_valid=0, out_y=0, out_cout=0, out_ovf=0 and in_ready=1 during reset.
  - In-flight operations are discarded. The first handshake after reset release is processed normally.
- Data registers of empty stages may hold stale values; only valid-qualified outputs are checked, except the reset values above.

Test Plan (N=16, CHUNK=4, latency 3):
- Carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 3 cycles later y=0x0000, cout=1, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> y=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 -> y=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 add -> y=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x0001 sub -> y=0x7FFF, ovf=1, cout=1.
- Backpressure: stream 8 back-to-back ops, hold out_ready=0 for 5 cycles mid-stream -> in_ready falls after 3 ops are held, outputs stay stable while stalled, all 8 results appear in order with none lost.
- Reset mid-flight: 3 ops in the pipeline, pulse rst_n low for a partial cycle -> out_valid=0 and all outputs 0 immediately, none of the 3 emitted; the next op after release gives the correct result at latency 3.
- Random: 10k ops with random a, b, cin and sub, random in_valid/out_ready toggling, also with N=32/CHUNK=8 and N=8/CHUNK=8 -> every result matches a golden model {cout,y} = a + b_eff + c_eff, with ovf as defined; throughput is 1/cycle when out_ready is held at 1.
